// File: rtl/mem_loader_pkg.sv
// ============================================================================
// Module      : mem_loader_pkg
// Description : Opcodes, FSM state encoding and response codes for mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_loader_pkg;

  localparam logic [2:0] OP_WR_IMEM = 3'b000;
  localparam logic [2:0] OP_RD_IMEM = 3'b001;
  localparam logic [2:0] OP_WR_DMEM = 3'b010;
  localparam logic [2:0] OP_RD_DMEM = 3'b011;
  localparam logic [2:0] OP_RUN     = 3'b100;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RUN       = 3'd4,
    ST_RESP      = 3'd5,
    ST_VERIFY    = 3'd6
  } state_t;

  // Memory opcodes are 0xx: bit 1 picks the data memory, bit 0 means read.
  function automatic logic op_is_mem(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_dmem(input logic [2:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_read(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_cycle_counter.sv
// ============================================================================
// Module      : loader_cycle_counter
// Description : Loadable down-counter; o_done flags count==0, no wrap below 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module loader_cycle_counter
  import mem_loader_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module      : mem_loader
// Description : Host command initiator for CPU instruction/data memory ports
//               and CPU run control. Optional MEM_LOADER_VERIFY_EN adds an
//               automatic read-back check after every write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  input  logic [DATA_W-1:0] rdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              cpu_enable
);

  localparam logic [CNT_W-1:0] RD_WAIT_LOAD = CNT_W'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_accept;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_en;
  logic              w_cnt_done;
  logic              w_addr_en;
  logic              w_wdata_en;
  logic              w_wen;
  logic              w_ren;
  logic              w_capture;
  logic              w_dmem;
  logic [CNT_W-1:0]  w_run_n;
  logic [DATA_W-1:0] w_rdata;
  logic              w_verify_err;

  assign w_accept = cmd_valid && cmd_ready;
  assign w_run_n  = cmd_data[CNT_W-1:0];
  assign w_dmem   = op_is_dmem(r_op);
  assign w_rdata  = w_dmem ? rdata_ext_2 : rdata_ext;

`ifdef MEM_LOADER_VERIFY_EN
  assign w_verify_err = !op_is_read(r_op) && (w_rdata != r_data);
`else
  assign w_verify_err = RSP_OK;
`endif

  loader_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_load_val),
    .i_en      (w_cnt_en),
    .o_done    (w_cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    cmd_ready      = 1'b0;
    rsp_valid      = 1'b0;
    cpu_enable     = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_en       = 1'b0;
    w_addr_en      = 1'b0;
    w_wdata_en     = 1'b0;
    w_wen          = 1'b0;
    w_ren          = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst) begin
          if (op_is_mem(cmd_op)) begin
            w_next = op_is_read(cmd_op) ? ST_READ : ST_WRITE;
          end else if ((cmd_op == OP_RUN) && (w_run_n != '0)) begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_run_n - 1'b1;
            w_next         = ST_RUN;
          end else begin
            w_next = ST_RESP;
          end
        end
      end
      ST_WRITE: begin
        w_addr_en  = 1'b1;
        w_wdata_en = 1'b1;
        w_wen      = 1'b1;
`ifdef MEM_LOADER_VERIFY_EN
        w_next     = ST_VERIFY;
`else
        w_next     = ST_RESP;
`endif
      end
      ST_READ, ST_VERIFY: begin
        w_addr_en      = 1'b1;
        w_ren          = 1'b1;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = RD_WAIT_LOAD;
        w_next         = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        // Address stays on the bus until the data is captured.
        w_addr_en = 1'b1;
        w_cnt_en  = 1'b1;
        if (w_cnt_done) begin
          w_capture = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RUN: begin
        cpu_enable = 1'b1;
        w_cnt_en   = 1'b1;
        if (w_cnt_done) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= RSP_OK;
    end else if (w_accept) begin
      r_op       <= cmd_op;
      r_addr     <= cmd_addr;
      r_data     <= cmd_data;
      r_rsp_data <= (cmd_op == OP_RUN) ? DATA_W'(w_run_n) : '0;
      r_rsp_err  <= (op_is_mem(cmd_op) || (cmd_op == OP_RUN)) ? RSP_OK : RSP_ERR;
    end else if (w_capture) begin
      r_rsp_data <= w_rdata;
      r_rsp_err  <= w_verify_err;
    end
  end

  assign rsp_data    = rsp_valid ? r_rsp_data : '0;
  assign rsp_err     = rsp_valid ? r_rsp_err : RSP_OK;

  assign addr_ext    = (w_addr_en && !w_dmem) ? r_addr : '0;
  assign wdata_ext   = (w_wdata_en && !w_dmem) ? r_data : '0;
  assign wen_ext     = w_wen && !w_dmem;
  assign ren_ext     = w_ren && !w_dmem;
  assign addr_ext_2  = (w_addr_en && w_dmem) ? r_addr : '0;
  assign wdata_ext_2 = (w_wdata_en && w_dmem) ? r_data : '0;
  assign wen_ext_2   = w_wen && w_dmem;
  assign ren_ext_2   = w_ren && w_dmem;

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed self-checking bench for mem_loader with RD_LAT=1
//               memory models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_loader;

`ifdef MEM_LOADER_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] addr_ext, wdata_ext, rdata_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic        cpu_enable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable)
  );

  // One-cycle read latency memories
  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  always @(posedge clk) begin
    if (wen_ext)   imem[addr_ext[9:2]]   <= wdata_ext;
    if (ren_ext)   rdata_ext             <= imem[addr_ext[9:2]];
    if (wen_ext_2) dmem[addr_ext_2[9:2]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2           <= dmem[addr_ext_2[9:2]];
  end

  int n_wen = 0, n_ren = 0, n_wen2 = 0, n_ren2 = 0, n_en = 0, n_multi = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0, last_raddr2 = '0;
  always @(negedge clk) begin
    if (wen_ext) begin
      n_wen++;
      last_waddr = addr_ext;
      last_wdata = wdata_ext;
    end
    if (ren_ext) n_ren++;
    if (wen_ext_2) n_wen2++;
    if (ren_ext_2) begin
      n_ren2++;
      last_raddr2 = addr_ext_2;
    end
    if (cpu_enable) n_en++;
    if ($countones({wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable}) > 1) n_multi++;
  end

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input bit ack, output logic [31:0] rdat, output logic rerr, output int lat);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    while (lat < 400) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      @(posedge clk);
      lat++;
    end
    if (lat >= 400) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout op=%0d: no rsp_valid within 400 cycles", op);
    end
    rdat = rsp_data;
    rerr = rsp_err;
    if (ack) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, addr_ext, wdata_ext, wen_ext, ren_ext,
         addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2, cpu_enable} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got nonzero outputs cmd_ready=%b rsp_valid=%b cpu_enable=%b, want all 0",
               cmd_ready, rsp_valid, cpu_enable);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_wr_imem();
    logic [31:0] d; logic e; int lat; int s_wen, s_other;
    s_wen = n_wen; s_other = n_wen2 + n_ren2 + n_en;
    do_cmd(3'b000, 32'h4, 32'hDEADBEEF, 1'b1, d, e, lat);
    total++; if (n_wen - s_wen !== 1) begin bad++; $display("FAIL wr_imem_wen_count: got %0d want 1", n_wen - s_wen); end
    total++; if (last_waddr !== 32'h4) begin bad++; $display("FAIL wr_imem_addr: got %h want 00000004", last_waddr); end
    total++; if (last_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_imem_wdata: got %h want deadbeef", last_wdata); end
    total++; if (n_wen2 + n_ren2 + n_en - s_other !== 0) begin bad++; $display("FAIL wr_imem_other_strobes: got %0d want 0", n_wen2 + n_ren2 + n_en - s_other); end
    total++; if (lat !== WR_LAT) begin bad++; $display("FAIL wr_imem_latency: got %0d want %0d", lat, WR_LAT); end
`ifdef MEM_LOADER_VERIFY_EN
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_imem_data: got %h want deadbeef", d); end
`else
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wr_imem_data: got %h want 0", d); end
`endif
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_imem_err: got %b want 0", e); end
  endtask

  task automatic test_dmem_rw();
    logic [31:0] d; logic e; int lat; int s_ren2, s_wen2, s_ren;
    do_cmd(3'b010, 32'h10, 32'h12345678, 1'b1, d, e, lat);
    total++; if (dmem[4] !== 32'h12345678) begin bad++; $display("FAIL wr_dmem_store: got %h want 12345678", dmem[4]); end
    s_ren2 = n_ren2; s_wen2 = n_wen2;
    do_cmd(3'b011, 32'h10, 32'h0, 1'b1, d, e, lat);
    total++; if (n_ren2 - s_ren2 !== 1) begin bad++; $display("FAIL rd_dmem_ren_count: got %0d want 1", n_ren2 - s_ren2); end
    total++; if (n_wen2 - s_wen2 !== 0) begin bad++; $display("FAIL rd_dmem_wen_count: got %0d want 0", n_wen2 - s_wen2); end
    total++; if (last_raddr2 !== 32'h10) begin bad++; $display("FAIL rd_dmem_addr: got %h want 00000010", last_raddr2); end
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL rd_dmem_data: got %h want 12345678", d); end
    total++; if (lat !== 3) begin bad++; $display("FAIL rd_dmem_latency: got %0d want 3", lat); end
    s_ren = n_ren;
    do_cmd(3'b001, 32'h4, 32'h0, 1'b1, d, e, lat);
    total++; if (n_ren - s_ren !== 1) begin bad++; $display("FAIL rd_imem_ren_count: got %0d want 1", n_ren - s_ren); end
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_imem_data: got %h want deadbeef", d); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_imem_err: got %b want 0", e); end
  endtask

  task automatic test_run();
    logic [31:0] d; logic e; int lat; int s_en, s_mem;
    s_en = n_en; s_mem = n_wen + n_ren + n_wen2 + n_ren2;
    do_cmd(3'b100, 32'h0, 32'd5, 1'b1, d, e, lat);
    total++; if (n_en - s_en !== 5) begin bad++; $display("FAIL run5_enable_cycles: got %0d want 5", n_en - s_en); end
    total++; if (n_wen + n_ren + n_wen2 + n_ren2 - s_mem !== 0) begin bad++; $display("FAIL run5_strobes: got %0d want 0", n_wen + n_ren + n_wen2 + n_ren2 - s_mem); end
    total++; if (d !== 32'd5) begin bad++; $display("FAIL run5_data: got %0d want 5", d); end
    total++; if (lat !== 6) begin bad++; $display("FAIL run5_latency: got %0d want 6", lat); end
    s_en = n_en;
    do_cmd(3'b100, 32'h0, 32'd0, 1'b1, d, e, lat);
    total++; if (n_en - s_en !== 0) begin bad++; $display("FAIL run0_enable_cycles: got %0d want 0", n_en - s_en); end
    total++; if (d !== 32'd0) begin bad++; $display("FAIL run0_data: got %0d want 0", d); end
    total++; if (lat !== 1) begin bad++; $display("FAIL run0_latency: got %0d want 1", lat); end
  endtask

  task automatic test_illegal();
    logic [31:0] d; logic e; int lat; int s_all;
    logic [2:0] ops [2] = '{3'b111, 3'b101};
    for (int i = 0; i < 2; i++) begin
      s_all = n_wen + n_ren + n_wen2 + n_ren2 + n_en;
      do_cmd(ops[i], 32'h20, 32'hFFFF, 1'b1, d, e, lat);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL illegal_err op=%0d: got %b want 1", ops[i], e); end
      total++; if (d !== 32'h0) begin bad++; $display("FAIL illegal_data op=%0d: got %h want 0", ops[i], d); end
      total++; if (n_wen + n_ren + n_wen2 + n_ren2 + n_en - s_all !== 0) begin bad++; $display("FAIL illegal_side_effect op=%0d: got %0d strobe cycles want 0", ops[i], n_wen + n_ren + n_wen2 + n_ren2 + n_en - s_all); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat; int s_wen; int w;
    do_cmd(3'b011, 32'h10, 32'h0, 1'b0, d, e, lat);
    s_wen = n_wen;
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_addr = 32'h8; cmd_data = 32'h0000A5A5;
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d: got %b want 1", i, rsp_valid); end
      total++; if (rsp_data !== 32'h12345678) begin bad++; $display("FAIL stall_data cyc=%0d: got %h want 12345678", i, rsp_data); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d: got %b want 0", i, cmd_ready); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    total++; if (n_wen - s_wen !== 0) begin bad++; $display("FAIL stall_early_accept: got %0d writes want 0", n_wen - s_wen); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_ack_ready: got %b want 1", cmd_ready); end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    w = 0;
    while (w < 50) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) break;
      w++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    total++; if (n_wen - s_wen !== 1 || imem[2] !== 32'h0000A5A5) begin bad++; $display("FAIL second_cmd_write: got %0d writes mem=%h want 1 and 0000a5a5", n_wen - s_wen, imem[2]); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d; logic e; int lat; int s_en; int n_rsp;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b100; cmd_addr = '0; cmd_data = 32'd100;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++; if (cpu_enable !== 1'b1) begin bad++; $display("FAIL midrun_enable: got %b want 1", cpu_enable); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_err, addr_ext, wdata_ext, wen_ext, ren_ext,
         addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2, cpu_enable} !== '0) begin
      bad++;
      $display("FAIL midrun_reset_outputs: cpu_enable=%b cmd_ready=%b rsp_valid=%b want all 0",
               cpu_enable, cmd_ready, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    s_en = n_en; n_rsp = 0;
    rsp_ready = 1'b1;
    repeat (110) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n_rsp++;
    end
    rsp_ready = 1'b0;
    total++; if (n_rsp !== 0) begin bad++; $display("FAIL midrun_dropped_rsp: got %0d responses want 0", n_rsp); end
    total++; if (n_en - s_en !== 0) begin bad++; $display("FAIL midrun_enable_after: got %0d cycles want 0", n_en - s_en); end
    do_cmd(3'b000, 32'hC, 32'h0BADF00D, 1'b1, d, e, lat);
    total++; if (lat !== WR_LAT || e !== 1'b0) begin bad++; $display("FAIL post_reset_cmd: got lat=%0d err=%b want lat=%0d err=0", lat, e, WR_LAT); end
    total++; if (imem[3] !== 32'h0BADF00D) begin bad++; $display("FAIL post_reset_store: got %h want 0badf00d", imem[3]); end
  endtask

  task automatic test_exclusive_strobes();
    total++; if (n_multi !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_wr_imem();
    test_dmem_rw();
    test_run();
    test_illegal();
    test_back_to_back();
    test_reset_mid_run();
    test_exclusive_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
